// File: rtl/peripheral_ahb_slave_mem_if.sv
// peripheral_ahb_slave_mem_if: AHB-Lite bus signals between one master and this memory slave
interface peripheral_ahb_slave_mem_if #(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/peripheral_ahb_slave_mem.sv
// peripheral_ahb_slave_mem: AHB-Lite memory slave with fixed wait states and ERROR responses
module peripheral_ahb_slave_mem #(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic HCLK,
  input logic HRESET,
  peripheral_ahb_slave_mem_if.slave bus
);
  localparam int NB = HDATA_SIZE / 8;
  localparam int OB = $clog2(NB);
  localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
  state_t                  state_q, state_d;
  logic [HADDR_SIZE-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [2:0]              size_q, size_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [HDATA_SIZE-1:0]   hrdata_q, hrdata_d;
  logic [HDATA_SIZE-1:0]   mem [MEM_DEPTH];
  logic [HDATA_SIZE-1:0]   wdata_m, rd_word;
  logic [HADDR_SIZE-OB-1:0] idx_in, idx_q, rd_idx;
  logic [HADDR_SIZE-1:0]   amask;
  logic                    acc, err, we;
  logic                    unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};
  assign idx_in = bus.HADDR[HADDR_SIZE-1:OB];
  assign idx_q  = addr_q[HADDR_SIZE-1:OB];
  assign amask  = ~({HADDR_SIZE{1'b1}} << bus.HSIZE);
  assign err    = int'(idx_in) >= MEM_DEPTH || bus.HSIZE > 3'(OB) || |(bus.HADDR & amask);
  assign acc    = (state_q == IDLE || state_q == DATA || state_q == ERR2) && bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign we     = state_q == DATA && write_q;
  assign rd_idx = state_q == WAIT ? idx_q : idx_in;
  assign rd_word = (we && idx_q == rd_idx) ? wdata_m : mem[rd_idx[AW-1:0]];
  assign bus.HREADYOUT = !(state_q == WAIT || state_q == ERR1);
  assign bus.HRESP     = state_q == ERR1 || state_q == ERR2;
  assign bus.HRDATA    = hrdata_q;
  // merge the write data into the stored word on the addressed byte lanes only
  always_comb begin
    wdata_m = mem[idx_q[AW-1:0]];
    for (int b = 0; b < NB; b++)
      if (b >= int'(addr_q) % NB && b < int'(addr_q) % NB + (1 << size_q)) wdata_m[8*b+:8] = bus.HWDATA[8*b+:8];
  end
  // next-state, address-phase capture and read-data load
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    hrdata_d = hrdata_q;
    if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? DATA : WAIT;
    end else if (state_q == ERR1) begin
      state_d = ERR2;
    end else begin
      state_d = IDLE;
      if (acc) begin
        addr_d  = bus.HADDR;
        write_d = bus.HWRITE;
        size_d  = bus.HSIZE;
        cnt_d   = 4'(WAIT_STATES);
        state_d = err ? ERR1 : (WAIT_STATES > 0 ? WAIT : DATA);
      end
    end
    if (state_d == DATA && !write_d) hrdata_d = rd_word;
  end
  // state and captured registers; reset abandons any in-flight transfer
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      cnt_q    <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      hrdata_q <= hrdata_d;
    end
  end
  // memory array, written only on the completing edge of a write data phase
  always_ff @(posedge HCLK) begin
    if (we) mem[idx_q[AW-1:0]] <= wdata_m;
  end
endmodule

// File: doc/peripheral_ahb_slave_mem.md
Name: peripheral_ahb_slave_mem

Overview:
- AHB-Lite responder (slave) backed by a word-addressed memory, with a fixed programmable number of wait states and ERROR responses.
- Pairs with the AHB master bus-functional model in the BIU verification library as the other end of the same bus.
- Serves single, INCR, INCRx and WRAPx bursts as independent pipelined beats.
- Synthesizable; intended as both a bench target and a simple on-chip RAM peripheral.

Parameters:
- HADDR_SIZE, 16, address width.
- HDATA_SIZE, 32, data width; power of two, 8..1024.
- MEM_DEPTH, 256, number of HDATA_SIZE-bit words.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..15).

Ports:
- HCLK  in  1  bus clock, all logic on rising edge.
- HRESET  in  1  asynchronous reset, active-high.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_SIZE  byte address.
- HWDATA  in  HDATA_SIZE  write data (data phase).
- HRDATA  out  HDATA_SIZE  read data (data phase).
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; ignored.
- HPROT  in  4  protection; ignored.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-level ready (mux output).
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (async, HRESET=1): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, captured address-phase registers cleared. Memory contents are not cleared.
- Accept rule: an address phase is accepted on a rising edge with HSEL & HREADY & HTRANS[1]. HTRANS IDLE or BUSY, or HSEL=0, gives a zero-wait OKAY (no state change).
- On accept, capture address, HWRITE and HSIZE.
- Error check on the captured values:
  - word index (HADDR / (HDATA_SIZE/8)) >= MEM_DEPTH → error;
  - 2**HSIZE > HDATA_SIZE/8 → error;
  - HADDR not aligned to 2**HSIZE → error.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. On a legal accept with WAIT_STATES>0, go to WAIT with counter=WAIT_STATES. On a legal accept with WAIT_STATES=0, go to DATA. On an illegal accept, go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 1, go to DATA.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes on this edge. A new accept on the same edge follows the IDLE transitions; otherwise return to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, then ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; no memory access. A new accept on this edge follows the IDLE transitions (the master normally drives IDLE here).
- Latency: an OKAY data phase lasts WAIT_STATES+1 cycles; an ERROR lasts exactly 2 cycles.
- Write:
  - HWDATA is sampled only on the completing edge (DATA state, or IDLE-equivalent when WAIT_STATES=0).
  - Only byte lanes [addr%(HDATA_SIZE/8) .. +2**HSIZE-1] are updated; other bytes are preserved.
- Read:
  - HRDATA presents the full word at the captured index whenever HREADYOUT=1 in an OKAY data phase; the master selects the lanes.
  - HRDATA holds its last value otherwise.
- Hazard: a read address phase overlapping the data phase of a write to the same word returns the merged new data (forwarding). No stale read is allowed.
- Reset mid-transfer: the in-flight write is discarded and the FSM returns to IDLE immediately.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF @0x0010, then read @0x0010 → HRDATA=0xDEADBEEF, HREADYOUT never low, HRESP=0.
- WAIT_STATES=2: INCR4 write 0x11,0x22,0x33,0x44 @0x0020, INCR4 read back → each beat has exactly 2 HREADYOUT-low cycles; data matches.
- Byte writes: word @0x0040=0x00000000; write byte 0xAB @0x0042 (HSIZE=0) → read @0x0040 returns 0x00AB0000.
- Errors:
  - read @ word index MEM_DEPTH (0x0400 with defaults) → HREADYOUT=0,HRESP=1 then HREADYOUT=1,HRESP=1, then OKAY.
  - HSIZE=2 @0x0002 → same 2-cycle ERROR.
- Back-to-back write 0x12345678 @0x0080 immediately followed by read @0x0080 (pipelined) → read returns 0x12345678.
- Assert HRESET during WAIT of a write @0x0090 → HREADYOUT=1,HRESP=0 at once; subsequent read @0x0090 returns the pre-write value.
